// File: rtl/rst_seq_ctrl.sv
// Soft-reset sequencer: asserts three domain resets in order 2->1->0, holds, then
// releases them 0->1->2 with programmable spacing. Reset itself starts a release run.
module rst_seq_ctrl (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       req_i,
  input  logic [7:0] hold_cyc_i,
  input  logic [3:0] gap_cyc_i,
  output logic       nrst0_o,
  output logic       nrst1_o,
  output logic       nrst2_o,
  output logic       busy_o,
  output logic       done_o
);

  typedef enum logic [1:0] {IDLE, ASRT, HOLD, REL} state_t;

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [1:0]  stage_q, stage_d;
  logic [7:0]  hold_s_q, hold_s_d;
  logic [3:0]  gap_s_q, gap_s_d;
  logic [2:0]  nrst_q, nrst_d;
  logic        done_q, done_d;
  logic        busy_q, busy_d;
  logic        gap_hit;

  // Shadowed timing keeps a running sequence immune to input changes.
  assign gap_hit = (cnt_q == {4'b0000, gap_s_q});

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    stage_d  = stage_q;
    hold_s_d = hold_s_q;
    gap_s_d  = gap_s_q;
    nrst_d   = nrst_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_i) begin
          nrst_d[2] = 1'b0;
          stage_d   = 2'd1;
          cnt_d     = 8'd0;
          hold_s_d  = hold_cyc_i;
          gap_s_d   = gap_cyc_i;
          state_d   = ASRT;
        end
      end
      ASRT: begin
        if (gap_hit) begin
          nrst_d[stage_q] = 1'b0;
          cnt_d           = 8'd0;
          if (stage_q == 2'd0) state_d = HOLD;
          else                 stage_d = stage_q - 2'd1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      HOLD: begin
        if (cnt_q == hold_s_q) begin
          nrst_d[0] = 1'b1;
          cnt_d     = 8'd0;
          stage_d   = 2'd1;
          state_d   = REL;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      REL: begin
        if (gap_hit) begin
          nrst_d[stage_q] = 1'b1;
          cnt_d           = 8'd0;
          if (stage_q == 2'd2) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            stage_d = stage_q + 2'd1;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= HOLD;
      cnt_q    <= 8'd0;
      stage_q  <= 2'd0;
      hold_s_q <= hold_cyc_i;
      gap_s_q  <= gap_cyc_i;
      nrst_q   <= 3'b000;
      done_q   <= 1'b0;
      busy_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      stage_q  <= stage_d;
      hold_s_q <= hold_s_d;
      gap_s_q  <= gap_s_d;
      nrst_q   <= nrst_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end

  assign nrst0_o = nrst_q[0];
  assign nrst1_o = nrst_q[1];
  assign nrst2_o = nrst_q[2];
  assign busy_o  = busy_q;
  assign done_o  = done_q;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Directed bench for rst_seq_ctrl: per-edge expected outputs are derived from the
// event-time equations of each sequence, queued, and checked as each edge passes.
module tb_rst_seq_ctrl;

  logic       clk;
  logic       rst;
  logic       req;
  logic [7:0] hold_cyc;
  logic [3:0] gap_cyc;
  logic       nrst0, nrst1, nrst2, busy, done;

  rst_seq_ctrl dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .req_i      (req),
    .hold_cyc_i (hold_cyc),
    .gap_cyc_i  (gap_cyc),
    .nrst0_o    (nrst0),
    .nrst1_o    (nrst1),
    .nrst2_o    (nrst2),
    .busy_o     (busy),
    .done_o     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         edge_n;
    logic [2:0] nrst;
    logic       done;
    logic       busy;
  } exp_t;

  exp_t q[$];
  int   cyc;
  int   checks;
  int   passed;
  int   a;

  function automatic exp_t mk(input int k, input logic [2:0] n, input logic d, input logic b);
    exp_t e;
    e.edge_n = k;
    e.nrst   = n;
    e.done   = d;
    e.busy   = b;
    return e;
  endfunction

  // Release starting from the edge b where all resets are low and HOLD begins.
  task automatic push_release(input int b, input int h, input int g, input bit tail, input int stop);
    int t0, t1, t2, last;
    t0   = b + h + 1;
    t1   = t0 + g + 1;
    t2   = t1 + g + 1;
    last = tail ? t2 + 1 : t2;
    for (int k = b; k <= last; k++) begin
      if (k < stop)
        q.push_back(mk(k, {(k >= t2), (k >= t1), (k >= t0)}, (k == t2), (k < t2)));
    end
  endtask

  // Assertion accepted at edge a, followed by hold and release.
  task automatic push_assert(input int a0, input int g, input int h, input bit tail, input int stop);
    for (int k = a0; k < a0 + 2 * (g + 1); k++) begin
      if (k < stop)
        q.push_back(mk(k, {1'b0, (k < a0 + g + 1), 1'b1}, 1'b0, 1'b1));
    end
    push_release(a0 + 2 * (g + 1), h, g, tail, stop);
  endtask

  task automatic tick();
    exp_t e;
    @(posedge clk);
    cyc++;
    #1;
    while (q.size() > 0 && q[0].edge_n == cyc) begin
      e = q.pop_front();
      checks++;
      assert ({nrst2, nrst1, nrst0} === e.nrst) begin
        passed++;
      end else begin
        $error("FAIL nrst edge=%0d got=%b exp=%b", cyc, {nrst2, nrst1, nrst0}, e.nrst);
      end
      checks++;
      assert (done === e.done) begin
        passed++;
      end else begin
        $error("FAIL done edge=%0d got=%b exp=%b", cyc, done, e.done);
      end
      checks++;
      assert (busy === e.busy) begin
        passed++;
      end else begin
        $error("FAIL busy edge=%0d got=%b exp=%b", cyc, busy, e.busy);
      end
      $display("edge %0d: nrst=%b done=%b busy=%b", cyc, {nrst2, nrst1, nrst0}, done, busy);
    end
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (q.size() > 0 && guard < 2000) begin
      tick();
      guard++;
    end
    if (q.size() > 0) begin
      checks++;
      assert (q.size() == 0) else
        $error("FAIL drain_timeout got=%0d pending exp=0", q.size());
      q.delete();
    end
  endtask

  initial begin
    cyc      = -1;
    checks   = 0;
    passed   = 0;
    rst      = 1'b1;
    req      = 1'b0;
    hold_cyc = 8'd3;
    gap_cyc  = 4'd2;

    // Power-on reset, release with hold 3 / gap 2.
    push_release(cyc + 1, 3, 2, 1'b1, 1 << 30);
    tick();
    rst = 1'b0;
    drain();

    // Soft request held high: ignored while busy, re-accepted in the DONE cycle.
    hold_cyc = 8'd0;
    gap_cyc  = 4'd1;
    tick();
    req = 1'b1;
    a   = cyc + 1;
    push_assert(a, 1, 0, 1'b0, 1 << 30);
    push_assert(a + 10, 1, 0, 1'b1, 1 << 30);
    while (cyc < a + 10) tick();
    req = 1'b0;
    drain();

    // Inputs changed mid-sequence must not alter the running timing.
    hold_cyc = 8'd3;
    gap_cyc  = 4'd2;
    req      = 1'b1;
    a        = cyc + 1;
    push_assert(a, 2, 3, 1'b1, 1 << 30);
    tick();
    req      = 1'b0;
    hold_cyc = 8'd200;
    gap_cyc  = 4'd9;
    drain();
    tick();
    req = 1'b1;
    a   = cyc + 1;
    push_assert(a, 9, 200, 1'b1, 1 << 30);
    tick();
    req = 1'b0;
    drain();

    // Reset pulse during release with stage 0 already out of reset.
    hold_cyc = 8'd2;
    gap_cyc  = 4'd3;
    req      = 1'b1;
    a        = cyc + 1;
    push_assert(a, 3, 2, 1'b1, a + 12);
    tick();
    req = 1'b0;
    while (cyc < a + 11) tick();
    rst      = 1'b1;
    hold_cyc = 8'd1;
    gap_cyc  = 4'd0;
    push_release(a + 12, 1, 0, 1'b1, 1 << 30);
    tick();
    rst      = 1'b0;
    hold_cyc = 8'd50;
    gap_cyc  = 4'd7;
    drain();

    // Maximum hold and gap.
    rst      = 1'b1;
    hold_cyc = 8'd255;
    gap_cyc  = 4'd15;
    push_release(cyc + 1, 255, 15, 1'b1, 1 << 30);
    tick();
    rst = 1'b0;
    drain();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/rst_seq_ctrl.md
RST_SEQ_CTRL -- requirements
Module: rst_seq_ctrl

Interface
REQ-001 SHALL have one clock and one reset: the reset is synchronous and active-high.
REQ-002 CLK  input  1  sole clock; all state updates on rising edge.
REQ-003 RST  input  1  synchronous reset, active-high.
REQ-004 REQ  input  1  soft-reset request, level-sampled; accepted only in IDLE.
REQ-005 HOLD_CYC  input  8  all-stages-in-reset hold length, in cycles minus 1.
REQ-006 GAP_CYC  input  4  spacing between stage assert/release events, in cycles minus 1.
REQ-007 NRST0  output  1  stage-0 domain reset, active-low, first released and last asserted.
REQ-008 NRST1  output  1  stage-1 domain reset, active-low.
REQ-009 NRST2  output  1  stage-2 domain reset, active-low, last released and first asserted.
REQ-010 BUSY  output  1  high whenever state != IDLE.
REQ-011 DONE  output  1  one-cycle pulse when a release sequence completes.
REQ-012 All outputs SHALL be registered; no combinational input-to-output path.

Function
REQ-013 States SHALL be: IDLE, ASRT (ordered assertion), HOLD, REL (ordered release).
REQ-014 Internal SHALL include: 8-bit cnt, 2-bit stage index, and shadow registers hold_s and gap_s.
REQ-015 Shadow registers SHALL load HOLD_CYC/GAP_CYC every cycle RST=1 and on the edge REQ is accepted; they SHALL be held constant otherwise.
REQ-016 HOLD: each edge, if cnt==hold_s -> NRST0<=1, cnt<=0, stage<=1, go REL; else cnt<=cnt+1.
REQ-017 REL: each edge, if cnt==gap_s -> NRST[stage]<=1, cnt<=0; if stage==2 -> go IDLE and DONE<=1; else stage<=stage+1. Otherwise cnt<=cnt+1.
REQ-018 IDLE with REQ=1: on that edge NRST2<=0, stage<=1, cnt<=0, go ASRT; DONE<=0.
REQ-019 ASRT: each edge, if cnt==gap_s -> NRST[stage]<=0, cnt<=0; if stage==0 -> go HOLD; else stage<=stage-1. Otherwise cnt<=cnt+1.
REQ-020 REQ SHALL be ignored (not queued) in ASRT, HOLD and REL.
REQ-021 DONE SHALL be high for exactly the one cycle after the IDLE-entry edge. REQ=1 during that cycle SHALL be accepted.
REQ-022 Boundaries: HOLD_CYC=0 gives a 1-cycle hold; GAP_CYC=0 gives events on consecutive edges. cnt compares SHALL use zero-extended gap_s. cnt SHALL never wrap.
REQ-023 NRST outputs SHALL only change in the fixed order NRST2->NRST1->NRST0 (assert) and NRST0->NRST1->NRST2 (release); they SHALL never glitch.

Reset
REQ-024 RST=1 SHALL, at the edge, force NRST0..2=0, state=HOLD, cnt=0, stage=0, DONE=0, BUSY=1.
REQ-025 RST SHALL override any state mid-sequence, including ASRT and REL.
REQ-026 After RST falls, the release sequence SHALL run automatically with no REQ needed.

Verification
REQ-027 HOLD_CYC=3, GAP_CYC=2, RST low from edge 1:
- NRST0 rises at edge 4.
- NRST1 rises at edge 7.
- NRST2 rises at edge 10.
- DONE high for exactly the cycle after edge 10.
- BUSY low after edge 10.
REQ-028 IDLE, HOLD_CYC=0, GAP_CYC=1, REQ pulse at edge a:
- NRST2 falls at a, NRST1 falls at a+2, NRST0 falls at a+4.
- NRST0 rises at a+5, NRST1 rises at a+7, NRST2 rises at a+9.
- DONE pulses after a+9.
REQ-029 Hold REQ=1 continuously throughout the REQ-028 sequence -> no extra events while busy; a new sequence starts at edge a+10 (the DONE cycle).
REQ-030 Assert RST for one cycle while in REL with NRST0=1 -> all NRST=0 at that edge, then a full release runs with freshly sampled HOLD_CYC/GAP_CYC.
REQ-031 Change HOLD_CYC 3->200 and GAP_CYC 2->9 mid-sequence -> timing unchanged from the sampled values; the new values apply only on the next REQ.
REQ-032 HOLD_CYC=255, GAP_CYC=15 -> NRST0 rises at edge 256, NRST2 rises at edge 288, cnt never wraps.
